// File: rtl/tau_uart_framer.sv
// tau_uart_framer: packs each yin tau result into a 4-byte UART frame
// (sync, tau high, tau low, checksum) with a one-deep latest-wins buffer.
module tau_uart_framer #(
  parameter int unsigned TAU_WIDTH = 11,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [TAU_WIDTH-1:0] tau_in,
  input  logic                 tau_valid_in,
  input  logic                 tx_busy_in,
  output logic [7:0]           data_byte_out,
  output logic                 trigger_out,
  output logic [15:0]          frames_sent_out,
  output logic [15:0]          frames_dropped_out,
  output logic                 busy_out,
  output logic [1:0]           state_out
);

  // UART handshake: a byte is offered by a one-cycle trigger_out pulse with
  // data_byte_out stable, and only while tx_busy_in is low; the UART raises
  // tx_busy_in the next cycle and holds it until the byte has left the wire.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] frame_val, frame_nxt;
  logic [15:0] pend_val, pend_val_nxt;
  logic        pend_full, pend_full_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [1:0]  ack_cnt, ack_nxt;
  logic [15:0] sent_nxt, dropped_nxt;
  logic        trigger_nxt;
  logic [7:0]  data_nxt;
  logic [7:0]  checksum;
  logic [7:0]  byte_sel;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign state_out = state;
  assign checksum  = SYNC_BYTE + frame_val[15:8] + frame_val[7:0];

  always_comb begin
    case (idx)
      2'd1:    byte_sel = frame_val[15:8];
      2'd2:    byte_sel = frame_val[7:0];
      2'd3:    byte_sel = checksum;
      default: byte_sel = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (tau_valid_in || pend_full) state_nxt = ST_ISSUE;
      ST_ISSUE:     if (!tx_busy_in) state_nxt = ST_WAIT_ACK;
      // A UART that never raises busy must not stall the frame.
      ST_WAIT_ACK:  if (tx_busy_in || ack_cnt == 2'd3) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy_in) state_nxt = (idx == 2'd3) ? ST_IDLE : ST_ISSUE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_nxt     = frame_val;
    pend_val_nxt  = pend_val;
    pend_full_nxt = pend_full;
    idx_nxt       = idx;
    ack_nxt       = ack_cnt;
    sent_nxt      = frames_sent_out;
    dropped_nxt   = frames_dropped_out;
    trigger_nxt   = 1'b0;
    data_nxt      = data_byte_out;

    if (state == ST_IDLE) begin
      idx_nxt = 2'd0;
      if (tau_valid_in) begin
        frame_nxt = 16'(tau_in);
        if (pend_full) begin
          pend_full_nxt = 1'b0;
          dropped_nxt   = sat_inc(frames_dropped_out);
        end
      end else if (pend_full) begin
        frame_nxt     = pend_val;
        pend_full_nxt = 1'b0;
      end
    end else if (tau_valid_in) begin
      // Mid-frame arrivals never touch frame_val; only the newest is kept.
      pend_val_nxt  = 16'(tau_in);
      pend_full_nxt = 1'b1;
      if (pend_full) dropped_nxt = sat_inc(frames_dropped_out);
    end

    case (state)
      ST_ISSUE: if (!tx_busy_in) begin
        trigger_nxt = 1'b1;
        data_nxt    = byte_sel;
        ack_nxt     = 2'd0;
      end
      ST_WAIT_ACK: if (!tx_busy_in) ack_nxt = ack_cnt + 2'd1;
      ST_WAIT_DONE: if (!tx_busy_in) begin
        if (idx == 2'd3) sent_nxt = sat_inc(frames_sent_out);
        else             idx_nxt  = idx + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_val          <= 16'd0;
      pend_val           <= 16'd0;
      pend_full          <= 1'b0;
      idx                <= 2'd0;
      ack_cnt            <= 2'd0;
      frames_sent_out    <= 16'd0;
      frames_dropped_out <= 16'd0;
      trigger_out        <= 1'b0;
      data_byte_out      <= 8'h00;
      busy_out           <= 1'b0;
    end else begin
      frame_val          <= frame_nxt;
      pend_val           <= pend_val_nxt;
      pend_full          <= pend_full_nxt;
      idx                <= idx_nxt;
      ack_cnt            <= ack_nxt;
      frames_sent_out    <= sent_nxt;
      frames_dropped_out <= dropped_nxt;
      trigger_out        <= trigger_nxt;
      data_byte_out      <= data_nxt;
      busy_out           <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tau_uart_framer.sv
// Bench for tau_uart_framer: UART busy model, byte monitor, frame-level
// reference model and directed plus randomized frame sequences.
module tb_tau_uart_framer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] tau_in = '0;
  logic        tau_valid_in = 1'b0;
  logic        tx_busy_in = 1'b0;
  logic [7:0]  data_byte_out;
  logic        trigger_out;
  logic [15:0] frames_sent_out;
  logic [15:0] frames_dropped_out;
  logic        busy_out;
  logic [1:0]  state_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_left = 0;
  bit ack_en = 1'b1;
  bit prev_trig = 1'b0;
  int double_trig = 0;
  int exp_sent = 0;
  int exp_dropped = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         trig_cyc[$];

  tau_uart_framer dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .tau_in             (tau_in),
    .tau_valid_in       (tau_valid_in),
    .tx_busy_in         (tx_busy_in),
    .data_byte_out      (data_byte_out),
    .trigger_out        (trigger_out),
    .frames_sent_out    (frames_sent_out),
    .frames_dropped_out (frames_dropped_out),
    .busy_out           (busy_out),
    .state_out          (state_out)
  );

  always #5 clk_in = ~clk_in;

  // UART model: busy for 20 cycles starting the cycle after a trigger.
  always @(posedge clk_in) begin
    cyc++;
    if (trigger_out && ack_en) busy_left = 20;
    else if (busy_left > 0)    busy_left--;
    tx_busy_in <= (busy_left > 0);
  end

  always @(negedge clk_in) begin
    if (trigger_out) begin
      got_q.push_back(data_byte_out);
      trig_cyc.push_back(cyc);
      if (prev_trig) double_trig++;
    end
    prev_trig = trigger_out;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync, high byte, low byte, modulo-256 sum of the three.
  task automatic push_frame(input int t);
    int hi, lo;
    hi = t / 256;
    lo = t % 256;
    exp_q.push_back(8'(165));
    exp_q.push_back(8'(hi));
    exp_q.push_back(8'(lo));
    exp_q.push_back(8'((165 + hi + lo) % 256));
  endtask

  task automatic strobe(input logic [10:0] t);
    @(negedge clk_in);
    tau_in = t;
    tau_valid_in = 1'b1;
    @(negedge clk_in);
    tau_valid_in = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int waited;
    waited = 0;
    while (got_q.size() < n && waited < 2000) begin
      @(negedge clk_in);
      waited++;
    end
    check({tag, "_bytes_seen"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    while (busy_out !== 1'b0 && waited < 500) begin
      @(negedge clk_in);
      waited++;
    end
    check({tag, "_idle"}, 32'(busy_out), 32'd0);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    logic [7:0] e, g;
    n = exp_q.size();
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front();
      else                  g = 8'hxx;
      check($sformatf("%s_b%0d", tag, i), 32'(g), 32'(e));
    end
    got_q.delete();
    check({tag, "_sent"}, 32'(frames_sent_out), 32'(exp_sent));
    check({tag, "_dropped"}, 32'(frames_dropped_out), 32'(exp_dropped));
  endtask

  task automatic run_frame(input logic [10:0] t, input string tag);
    push_frame(int'(t));
    strobe(t);
    wait_bytes(4, tag);
    wait_idle(tag);
    exp_sent++;
    compare_frames(tag);
  endtask

  initial begin
    logic [10:0] a, last_v;
    int k, sp;

    repeat (3) @(negedge clk_in);
    check("rst_trigger", 32'(trigger_out), 32'd0);
    check("rst_data", 32'(data_byte_out), 32'd0);
    check("rst_sent", 32'(frames_sent_out), 32'd0);
    check("rst_dropped", 32'(frames_dropped_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single frame with first-trigger latency: strobe at N, trigger at N+2.
    push_frame(16'h4D3);
    tau_in = 11'h4D3;
    tau_valid_in = 1'b1;
    @(negedge clk_in);
    tau_valid_in = 1'b0;
    check("lat_n1_trigger", 32'(trigger_out), 32'd0);
    check("lat_n1_busy", 32'(busy_out), 32'd1);
    @(negedge clk_in);
    check("lat_n2_trigger", 32'(trigger_out), 32'd1);
    check("lat_n2_data", 32'(data_byte_out), 32'hA5);
    wait_bytes(4, "single");
    wait_idle("single");
    exp_sent++;
    compare_frames("single");

    run_frame(11'h7FF, "max");
    run_frame(11'h000, "zero");
    for (int i = 0; i < 3; i++) run_frame(11'($urandom_range(0, 2047)), $sformatf("rand%0d", i));

    // Overwrite: the middle value is dropped, the last one is sent next.
    push_frame(16'h100);
    push_frame(16'h020);
    strobe(11'h100);
    wait_bytes(1, "ovw_first");
    strobe(11'h010);
    repeat (5) @(negedge clk_in);
    strobe(11'h020);
    exp_dropped++;
    wait_bytes(8, "ovw");
    wait_idle("ovw");
    exp_sent += 2;
    compare_frames("ovw");

    for (int r = 0; r < 2; r++) begin
      a = 11'($urandom_range(0, 2047));
      push_frame(int'(a));
      strobe(a);
      wait_bytes(1, "rovw_first");
      k = $urandom_range(2, 4);
      last_v = '0;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(1, 10)) @(negedge clk_in);
        last_v = 11'($urandom_range(0, 2047));
        strobe(last_v);
      end
      push_frame(int'(last_v));
      exp_dropped += k - 1;
      wait_bytes(8, "rovw");
      wait_idle("rovw");
      exp_sent += 2;
      compare_frames($sformatf("rovw%0d", r));
    end

    // Coincident arrival on the last busy-low cycle of WAIT_DONE.
    push_frame(16'h055);
    push_frame(16'h123);
    strobe(11'h055);
    wait_bytes(4, "coin_first");
    k = 0;
    while (!tx_busy_in && k < 100) begin @(negedge clk_in); k++; end
    while (tx_busy_in && k < 200) begin @(negedge clk_in); k++; end
    tau_in = 11'h123;
    tau_valid_in = 1'b1;
    @(negedge clk_in);
    tau_valid_in = 1'b0;
    wait_bytes(8, "coin");
    wait_idle("coin");
    exp_sent += 2;
    compare_frames("coin");

    // Asynchronous reset after byte index 2 has been triggered.
    push_frame(16'h2AA);
    strobe(11'h2AA);
    wait_bytes(3, "rstmid");
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rstmid_trigger", 32'(trigger_out), 32'd0);
    check("rstmid_data", 32'(data_byte_out), 32'd0);
    check("rstmid_busy", 32'(busy_out), 32'd0);
    check("rstmid_sent", 32'(frames_sent_out), 32'd0);
    check("rstmid_dropped", 32'(frames_dropped_out), 32'd0);
    exp_q.delete();
    got_q.delete();
    exp_sent = 0;
    exp_dropped = 0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    run_frame(11'h4D3, "after_rst");

    // Missing ack: UART never raises busy, frame still completes.
    ack_en = 1'b0;
    repeat (25) @(negedge clk_in);
    trig_cyc.delete();
    run_frame(11'($urandom_range(0, 2047)), "noack");
    if (trig_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        sp = trig_cyc[i] - trig_cyc[i-1];
        check($sformatf("noack_gap%0d_in_5_to_7", i), 32'(sp >= 5 && sp <= 7), 32'd1);
      end
    end
    check("noack_trig_count", 32'(trig_cyc.size()), 32'd4);

    check("trigger_single_cycle", 32'(double_trig), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tau_uart_framer.md
# tau_uart_framer

Packetizer between the `yin` pitch detector and `uart_transmit`. It captures each `taumin` result and serializes it as a fixed 4-byte frame: sync, high byte, low byte, checksum. Bytes are handed one at a time to the UART through its `trigger`/`busy` handshake. A one-entry latest-wins buffer absorbs results that arrive while a frame is in flight, and saturating counters report sent and dropped frames.

## Interface

Parameters:
- `TAU_WIDTH`, default 11. Width of the tau input. Legal range is 9..16.
- `SYNC_BYTE`, default 8'hA5. First byte of every frame.

Ports:
- `clk_in`, input, 1. System clock, 100 MHz.
- `rst_in`, input, 1. Reset, asynchronous and active-low.
- `tau_in`, input, TAU_WIDTH. Pitch period from `yin`.
- `tau_valid_in`, input, 1. One-cycle strobe; `tau_in` is valid in that cycle.
- `tx_busy_in`, input, 1. `busy_out` of `uart_transmit`.
- `data_byte_out`, output, 8. Connects to `data_byte_in` of the UART.
- `trigger_out`, output, 1. Connects to `trigger_in` of the UART; one-cycle pulse.
- `frames_sent_out`, output, 16. Completed frames; saturates at 16'hFFFF.
- `frames_dropped_out`, output, 16. Overwritten pending values; saturates at 16'hFFFF.
- `busy_out`, output, 1. High in any state other than IDLE.

## Operation

Frame format, computed from the captured value T:
- b0 = SYNC_BYTE.
- b1 = T[15:8], with T zero-extended to 16 bits.
- b2 = T[7:0].
- b3 = (b0 + b1 + b2) mod 256.

State machine:
- **IDLE**
  - If `tau_valid_in` is high, capture `tau_in`, load the byte index with 0, and go to ISSUE.
  - Otherwise, if the pending buffer is full, capture the pending value, clear pending, and go to ISSUE.
- **ISSUE**
  - When `tx_busy_in` is low, drive `data_byte_out` with byte[index], pulse `trigger_out` for exactly one cycle, and go to WAIT_ACK.
  - While `tx_busy_in` is high, stay in ISSUE.
- **WAIT_ACK**
  - Wait for `tx_busy_in` to go high, then go to WAIT_DONE.
  - The UART raises busy the cycle after the trigger.
  - If busy has not risen after 4 cycles, treat the byte as accepted and go to WAIT_DONE.
- **WAIT_DONE**
  - Wait for `tx_busy_in` to go low.
  - If index is less than 3: increment index and go to ISSUE.
  - If index is 3: increment `frames_sent_out` and go to IDLE.

Pending buffer:
- A `tau_valid_in` in any non-IDLE state writes the pending register and sets the pending-full flag.
- If the flag was already set, the older value is overwritten and `frames_dropped_out` increments.
- Simultaneous events:
  - If `tau_valid_in` coincides with the last WAIT_DONE cycle, the value goes to pending. The next frame starts from pending on the following IDLE cycle.
  - If a value is arriving in IDLE while pending is full, the new arrival wins. Pending is discarded and counted as dropped. This case is not reachable in normal flow and is defined for completeness.
- The captured frame value never changes mid-frame.

Reset (`rst_in` low, asynchronous, at any point including mid-frame) forces:
- state IDLE;
- `trigger_out` = 0, `data_byte_out` = 8'h00;
- counters = 0, pending cleared, `busy_out` = 0.

A partially sent frame is abandoned. Receivers resynchronize on SYNC_BYTE.

## Timing

- All outputs are registered.
- A strobe at cycle N in IDLE, with `tx_busy_in` low, produces the first `trigger_out` at cycle N+2: capture at N+1, ISSUE trigger at N+2.
- `data_byte_out` is valid in the `trigger_out` cycle and held until the next trigger.
- Consecutive triggers are separated by the full UART busy period plus 2 cycles.
- Throughput at 460800 baud is about 87 µs per frame. Any result arriving faster than that is subject to latest-wins dropping.

## Test plan

- **Single frame.** UART model raises busy 1 cycle after trigger for 20 cycles. Strobe `tau_in` = 11'h4D3 → triggers carry A5, 04, D3, 7C in order; `frames_sent_out` = 1; `busy_out` returns to 0.
- **Boundary values.** `tau_in` = 11'h7FF → A5, 07, FF, AB. `tau_in` = 0 → A5, 00, 00, A5.
- **Overwrite.** Strobe 11'h100. During its frame, strobe 11'h010 and then 11'h020 → second frame carries A5, 00, 20, C5; `frames_dropped_out` = 1; `frames_sent_out` = 2.
- **Coincident arrival.** Strobe 11'h123 on the final WAIT_DONE cycle → the next frame (A5, 01, 23, C9) starts with no drop counted.
- **Reset mid-frame.** Pull `rst_in` low after byte 2 has been triggered → outputs are 0 within the same cycle as the asynchronous assert. After release, a new strobe of 11'h4D3 produces a full A5, 04, D3, 7C frame.
- **Missing ack.** UART model never raises busy → all 4 triggers still issue, each roughly 6 cycles apart, with no hang.
